// File: rtl/io_pkg.sv
// Shared I/O definitions for the CPU port peripherals: UART FSM states,
// status byte bit positions and port index assignments.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Bit positions inside the status byte returned on the CPU input port
    localparam int STATUS_BUSY  = 0;
    localparam int STATUS_FULL  = 1;
    localparam int STATUS_EMPTY = 2;
    localparam int STATUS_OVF   = 3;

    // Output port carrying TX bytes; port 15 remains the simulation-stop port
    localparam int TX_PORT = 14;

endpackage

// File: rtl/byte_fifo.sv
// Parameterized synchronous FIFO. Pointers carry one extra wrap bit so
// full and empty fall straight out of a pointer compare.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    logic do_push;
    logic do_pop;

    // Guard against caller misuse so the pointers never cross
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Storage array; contents need no reset since empty gates every read
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointer update; the extra MSB wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/port_uart_tx.sv
// CPU output-port UART transmitter: bytes written to the TX port are
// queued in a small FIFO and shifted out as 8N1 frames, LSB first.
module port_uart_tx
    import io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       clr_ovf,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic [7:0] status
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;

    logic       fifo_push;
    logic       fifo_pop;
    logic [7:0] fifo_dout;

    // Fullness is the pre-pop value, so a pop never rescues a write made while full
    assign fifo_push = wr_en && !full;
    assign fifo_pop  = (state == IDLE) && !empty;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    // Frame sequencer; tx and busy are registered alongside the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud <= '0;
                    if (!empty) begin
                        shift   <= fifo_dout;
                        bit_cnt <= '0;
                        state   <= START;
                        busy    <= 1'b1;
                        tx      <= 1'b0;
                    end
                end
                START: begin
                    if (baud == BAUD_LAST) begin
                        baud  <= '0;
                        state <= DATA;
                        tx    <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud == BAUD_LAST) begin
                        baud <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud == BAUD_LAST) begin
                        baud  <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        tx    <= 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                    baud  <= '0;
                end
            endcase
        end
    end

    // Sticky overflow; a dropped write wins over a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overflow <= 1'b0;
        else if (wr_en && full)
            overflow <= 1'b1;
        else if (clr_ovf)
            overflow <= 1'b0;
    end

    // Status byte for the CPU input port
    always_comb begin
        status               = '0;
        status[STATUS_BUSY]  = busy;
        status[STATUS_FULL]  = full;
        status[STATUS_EMPTY] = empty;
        status[STATUS_OVF]   = overflow;
    end

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx: directed scenarios plus random traffic, each
// cycle compared against a frame-timeline model built on a byte queue.
module tb_port_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       tx;
    logic       busy;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [7:0] status;

    int checks;
    int errors;

    // Reference model: queued bytes, the frame on the wire and its age
    logic [7:0] mq[$];
    bit         fr_act;
    logic [7:0] fr_byte;
    int         fr_t;
    bit         m_ovf;

    port_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .clr_ovf  (clr_ovf),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .status   (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int t);
        int k;
        k = t / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    task automatic model_reset();
        mq.delete();
        fr_act  = 0;
        fr_byte = '0;
        fr_t    = 0;
        m_ovf   = 0;
    endtask

    // One clock edge of the model, using inputs as sampled at that edge
    task automatic model_step(input logic we, input logic [7:0] d, input logic co);
        bit full_pre;
        bit empty_pre;
        full_pre  = (mq.size() == DEPTH);
        empty_pre = (mq.size() == 0);
        if (fr_act) begin
            fr_t++;
            if (fr_t == FRAME) fr_act = 0;
        end else if (!empty_pre) begin
            fr_byte = mq.pop_front();
            fr_act  = 1;
            fr_t    = 0;
        end
        if (we && !full_pre) mq.push_back(d);
        if (we && full_pre) m_ovf = 1;
        else if (co) m_ovf = 0;
    endtask

    task automatic check_outputs();
        logic       e_tx;
        logic       e_full;
        logic       e_empty;
        logic [7:0] e_stat;
        e_tx    = fr_act ? frame_bit(fr_byte, fr_t) : 1'b1;
        e_full  = (mq.size() == DEPTH);
        e_empty = (mq.size() == 0);
        e_stat  = {4'b0, m_ovf, e_empty, e_full, fr_act};
        chk("tx",       {7'b0, tx},       {7'b0, e_tx});
        chk("busy",     {7'b0, busy},     {7'b0, fr_act});
        chk("full",     {7'b0, full},     {7'b0, e_full});
        chk("empty",    {7'b0, empty},    {7'b0, e_empty});
        chk("overflow", {7'b0, overflow}, {7'b0, m_ovf});
        chk("status",   status,           e_stat);
    endtask

    // Drive inputs from a negedge, clock once, compare at the next negedge
    task automatic tick(input logic we, input logic [7:0] d, input logic co);
        wr_en   = we;
        wr_data = d;
        clr_ovf = co;
        @(posedge clk);
        model_step(we, d, co);
        @(negedge clk);
        wr_en   = 1'b0;
        wr_data = 8'($urandom);
        clr_ovf = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom), 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must settle at once
    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_tx",     {7'b0, tx},    8'h01);
        chk("rst_status", status,        8'h04);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_outputs();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        clr_ovf = 1'b0;
        reset   = 1'b0;
        model_reset();
        #23;
        chk("reset_tx",     {7'b0, tx}, 8'h01);
        chk("reset_status", status,     8'h04);
        @(negedge clk);
        reset = 1'b1;

        // Quiet line after reset
        idle(50);
        chk("idle_status", status, 8'h04);

        // Single frame
        tick(1'b1, 8'hA5, 1'b0);
        idle(50);
        chk("a5_done_status", status, 8'h04);

        // Three back-to-back bytes
        tick(1'b1, 8'h01, 1'b0);
        tick(1'b1, 8'h02, 1'b0);
        tick(1'b1, 8'h03, 1'b0);
        idle(140);

        // Overflow: six writes into four entries plus the shifter
        for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'h10 + i), 1'b0);
        chk("ovf_set", status & 8'h08, 8'h08);
        // Clear coinciding with another dropped write: set wins
        tick(1'b1, 8'h16, 1'b1);
        chk("ovf_set_wins", {7'b0, overflow}, 8'h01);
        tick(1'b0, 8'h00, 1'b1);
        chk("ovf_cleared", {7'b0, overflow}, 8'h00);
        idle(230);

        // Reset in the middle of a DATA phase with two bytes queued
        tick(1'b1, 8'hFF, 1'b0);
        tick(1'b1, 8'h55, 1'b0);
        tick(1'b1, 8'h66, 1'b0);
        idle(CPB + 6);
        chk("pre_rst_busy", {7'b0, busy}, 8'h01);
        async_reset();
        idle(60);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 24) == 0), 8'($urandom), ($urandom_range(0, 60) == 0));
            if (i == 1500) async_reset();
        end
        idle(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
